// File: rtl/sram_port_arbiter.sv
// Purpose: arbitrates two requesters onto one single-port SRAM, zero-filling it after reset.
// Latency: grant and SRAM command are combinational; read data valid one cycle after the grant.
// Backpressure: a requester without a grant holds its request stable; nothing is buffered here.
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024,
    parameter int INIT_ZERO  = 1,
    localparam int AW        = $clog2(NUM_WORDS),
    localparam int BW        = (DATA_WIDTH + 7) / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 we_i,
    input  logic [1:0][AW-1:0]         addr_i,
    input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [1:0][BW-1:0]         be_i,
    output logic [1:0]                 gnt_o,
    output logic [1:0]                 rvalid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       init_done_o,
    output logic                       sram_req_o,
    output logic                       sram_we_o,
    output logic [AW-1:0]              sram_addr_o,
    output logic [DATA_WIDTH-1:0]      sram_wdata_o,
    output logic [BW-1:0]              sram_be_o,
    input  logic [DATA_WIDTH-1:0]      sram_rdata_i
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_WORDS - 1);
    localparam state_t        RESET_ST   = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    localparam logic          RESET_DONE = (INIT_ZERO == 0);

    state_t          state_q, state_d;
    logic [AW-1:0]   init_cnt_q, init_cnt_d;
    logic            last_grant_q, last_grant_d;
    logic [1:0]      rvalid_q, rvalid_d;
    logic            init_done_q;
    logic            sel;

    // State, zero-fill counter, round-robin pointer and read-valid pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RESET_ST;
            init_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rvalid_q     <= '0;
            init_done_q  <= RESET_DONE;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            last_grant_q <= last_grant_d;
            rvalid_q     <= rvalid_d;
            init_done_q  <= (state_d == ST_RUN);
        end
    end

    // Next state, grant selection and SRAM command mux.
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        last_grant_d = last_grant_q;
        rvalid_d     = '0;
        gnt_o        = '0;
        sel          = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;

        case (state_q)
            ST_INIT: begin
                // One zero write per cycle; requesters are locked out until done.
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_be_o   = '1;
                sram_addr_o = init_cnt_q;
                init_cnt_d  = init_cnt_q + AW'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                // On contention the requester that did not win last time goes first.
                if (req_i == 2'b11) begin
                    gnt_o = last_grant_q ? 2'b01 : 2'b10;
                end else begin
                    gnt_o = req_i;
                end
                sel = gnt_o[1];
                if (gnt_o != 2'b00) begin
                    sram_req_o    = 1'b1;
                    sram_we_o     = we_i[sel];
                    sram_addr_o   = addr_i[sel];
                    sram_wdata_o  = wdata_i[sel];
                    sram_be_o     = be_i[sel];
                    last_grant_d  = sel;
                    rvalid_d[sel] = ~we_i[sel];
                end
            end
            default: begin
                state_d = RESET_ST;
            end
        endcase
    end

    // A reset landing while read data is being returned drops that valid immediately.
    assign rvalid_o    = rvalid_q & {2{~rst_i}};
    assign rdata_o     = sram_rdata_i;
    assign init_done_o = init_done_q;

endmodule
